// File: rtl/clk_gate_req_ctrl.sv
// rtl/clk_gate_req_ctrl.sv - enable-side controller for a clock NAND gating cell
//
// Purpose: runs a gated clock branch on request. Requesters use a 4-phase
// clkreq/clkack handshake. The block raises clken, waits WAKE_DLY cycles for the
// branch to settle and then acknowledges. Once the request drops it keeps the
// clock running for hyst_val idle cycles before gating it off.
//
// Ports:
//   clk        free-running (ungated) clock
//   rst_b      asynchronous active-low reset
//   clkreq     clock request, already synchronous to clk
//   force_on   debug/DFT override, keeps the clock running
//   hyst_val   idle cycles before gate-off, sampled on ON->IDLE entry
//   clken      registered enable to the gating cell (1 = clock runs)
//   clkack     registered handshake acknowledge
//   gate_state FSM state: OFF=0, WAKE=1, ON=2, IDLE=3

module clk_gate_req_ctrl #(
    parameter int WAKE_DLY = 2,
    parameter int HYST_W   = 4
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              clkreq,
    input  logic              force_on,
    input  logic [HYST_W-1:0] hyst_val,
    output logic              clken,
    output logic              clkack,
    output logic [1:0]        gate_state
);

    localparam int WCNT_W = $clog2(WAKE_DLY + 1);
    localparam logic [WCNT_W-1:0] WAKE_LOAD = WCNT_W'(WAKE_DLY);
    localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
    localparam logic [HYST_W-1:0] HCNT_ONE  = HYST_W'(1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } state_t;

    state_t            state;
    logic [WCNT_W-1:0] wake_cnt;
    logic [HYST_W-1:0] hyst_cnt;
    logic              req_any;

    assign req_any    = clkreq | force_on;
    assign gate_state = state;

    // clken/clkack are updated only alongside state changes, straight from
    // flops, so the gating cell never sees a combinational glitch.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= ST_OFF;
            wake_cnt <= '0;
            hyst_cnt <= '0;
            clken    <= 1'b0;
            clkack   <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (req_any) begin
                        state    <= ST_WAKE;
                        wake_cnt <= WAKE_LOAD;
                        clken    <= 1'b1;
                    end
                end
                // Never aborted: the request is ignored until the settling
                // interval completes. The edge that would take the counter to
                // zero is the edge that enters ON.
                ST_WAKE: begin
                    if (wake_cnt <= WCNT_ONE) begin
                        state    <= ST_ON;
                        wake_cnt <= '0;
                        clkack   <= 1'b1;
                    end else begin
                        wake_cnt <= wake_cnt - WCNT_ONE;
                    end
                end
                ST_ON: begin
                    if (!req_any) begin
                        if (hyst_val == '0) begin
                            state  <= ST_OFF;
                            clken  <= 1'b0;
                            clkack <= 1'b0;
                        end else begin
                            state    <= ST_IDLE;
                            hyst_cnt <= hyst_val;
                        end
                    end
                end
                // A request beats expiry on the same edge. Leaving on the edge
                // that would reach zero makes IDLE last exactly hyst_val cycles.
                ST_IDLE: begin
                    if (req_any) begin
                        state    <= ST_ON;
                        hyst_cnt <= '0;
                    end else if (hyst_cnt <= HCNT_ONE) begin
                        state    <= ST_OFF;
                        hyst_cnt <= '0;
                        clken    <= 1'b0;
                        clkack   <= 1'b0;
                    end else begin
                        hyst_cnt <= hyst_cnt - HCNT_ONE;
                    end
                end
                default: begin
                    state  <= ST_OFF;
                    clken  <= 1'b0;
                    clkack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_gate_req_ctrl.sv
// tb/tb_clk_gate_req_ctrl.sv - directed table-driven bench for clk_gate_req_ctrl
module tb_clk_gate_req_ctrl;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       clkreq;
    logic       force_on;
    logic [3:0] hyst_val;
    logic       clken;
    logic       clkack;
    logic [1:0] gate_state;

    always #5 clk = ~clk;

    clk_gate_req_ctrl #(.WAKE_DLY(2), .HYST_W(4)) dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .clkreq     (clkreq),
        .force_on   (force_on),
        .hyst_val   (hyst_val),
        .clken      (clken),
        .clkack     (clkack),
        .gate_state (gate_state)
    );

    // expected = {clken, clkack, gate_state}
    localparam logic [3:0] E_OFF  = 4'b0000;
    localparam logic [3:0] E_WAKE = 4'b1001;
    localparam logic [3:0] E_ON   = 4'b1110;
    localparam logic [3:0] E_IDLE = 4'b1111;

    typedef struct {
        logic       req;
        logic       frc;
        logic [3:0] hyst;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic r, input logic f, input logic [3:0] h,
                                input logic [3:0] e);
        vec_t v;
        v.req  = r;
        v.frc  = f;
        v.hyst = h;
        v.exp  = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [3:0] exp);
        logic [3:0] got;
        got = {clken, clkack, gate_state};
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got {clken,clkack,state}=%b expected %b", name, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit
    // after the rising edge that consumes them.
    task automatic step(input logic r, input logic f, input logic [3:0] h);
        @(negedge clk);
        clkreq   = r;
        force_on = f;
        hyst_val = h;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_b    = 1'b1;
        clkreq   = 1'b0;
        force_on = 1'b0;
        hyst_val = 4'd3;
        #2 rst_b = 1'b0;
        #1 chk("reset_state", E_OFF);
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;

        // Basic handshake, hyst=3
        vecs.push_back(mk(0, 0, 3, E_OFF));
        vecs.push_back(mk(1, 0, 3, E_WAKE));
        vecs.push_back(mk(1, 0, 3, E_WAKE));
        vecs.push_back(mk(1, 0, 3, E_ON));
        vecs.push_back(mk(1, 0, 3, E_ON));
        vecs.push_back(mk(0, 0, 3, E_IDLE));
        vecs.push_back(mk(0, 0, 3, E_IDLE));
        vecs.push_back(mk(0, 0, 3, E_IDLE));
        vecs.push_back(mk(0, 0, 3, E_OFF));
        vecs.push_back(mk(0, 0, 3, E_OFF));
        // Zero hysteresis
        vecs.push_back(mk(1, 0, 0, E_WAKE));
        vecs.push_back(mk(1, 0, 0, E_WAKE));
        vecs.push_back(mk(1, 0, 0, E_ON));
        vecs.push_back(mk(0, 0, 0, E_OFF));
        // Immediate re-request after one OFF cycle, then re-request in IDLE
        vecs.push_back(mk(1, 0, 5, E_WAKE));
        vecs.push_back(mk(1, 0, 5, E_WAKE));
        vecs.push_back(mk(1, 0, 5, E_ON));
        vecs.push_back(mk(0, 0, 5, E_IDLE));
        vecs.push_back(mk(0, 0, 5, E_IDLE));
        vecs.push_back(mk(1, 0, 5, E_ON));
        vecs.push_back(mk(1, 0, 5, E_ON));
        // Collision: request on the edge the IDLE counter would expire;
        // hyst_val changes inside IDLE must not matter
        vecs.push_back(mk(0, 0, 4, E_IDLE));
        vecs.push_back(mk(0, 0, 0, E_IDLE));
        vecs.push_back(mk(0, 0, 0, E_IDLE));
        vecs.push_back(mk(0, 0, 0, E_IDLE));
        vecs.push_back(mk(1, 0, 0, E_ON));
        vecs.push_back(mk(0, 0, 0, E_OFF));
        // clkreq drops during WAKE, force_on rises during WAKE
        vecs.push_back(mk(1, 0, 2, E_WAKE));
        vecs.push_back(mk(0, 1, 2, E_WAKE));
        vecs.push_back(mk(0, 1, 2, E_ON));
        vecs.push_back(mk(0, 0, 2, E_IDLE));
        vecs.push_back(mk(0, 0, 2, E_IDLE));
        vecs.push_back(mk(0, 0, 2, E_OFF));
        // clkreq dropped during WAKE without override: ON, then IDLE
        vecs.push_back(mk(1, 0, 2, E_WAKE));
        vecs.push_back(mk(0, 0, 2, E_WAKE));
        vecs.push_back(mk(0, 0, 2, E_ON));
        vecs.push_back(mk(0, 0, 2, E_IDLE));
        vecs.push_back(mk(0, 0, 2, E_IDLE));
        vecs.push_back(mk(0, 0, 2, E_OFF));

        foreach (vecs[i]) begin
            step(vecs[i].req, vecs[i].frc, vecs[i].hyst);
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Override held for >100 cycles, then released with hyst=2
        step(0, 1, 2);
        chk("force_wake0", E_WAKE);
        step(0, 1, 2);
        chk("force_wake1", E_WAKE);
        step(0, 1, 2);
        chk("force_on_reached", E_ON);
        for (int c = 0; c < 110; c++) begin
            step(0, 1, 2);
            chk($sformatf("force_hold%0d", c), E_ON);
        end
        step(0, 0, 2);
        chk("force_rel_idle0", E_IDLE);
        step(0, 0, 2);
        chk("force_rel_idle1", E_IDLE);
        step(0, 0, 2);
        chk("force_rel_off", E_OFF);

        // Asynchronous reset in the middle of WAKE
        step(1, 0, 3);
        chk("pre_reset_wake", E_WAKE);
        #3 rst_b = 1'b0;
        #1 chk("reset_mid_wake", E_OFF);
        @(negedge clk);
        clkreq = 1'b0;
        rst_b  = 1'b1;
        step(0, 0, 3);
        chk("post_reset_off0", E_OFF);
        step(0, 0, 3);
        chk("post_reset_off1", E_OFF);
        step(1, 0, 3);
        chk("post_reset_wake", E_WAKE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_gate_req_ctrl.md
# clk_gate_req_ctrl

Enable-side controller for the clock NAND gating cell: it decides when a gated clock branch runs and drives the cell's enable leg. Consumers request the clock with a 4-phase `clkreq`/`clkack` handshake. The block asserts `clken`, waits a fixed settling interval, then acknowledges. After the request drops, it holds the clock on for a programmable hysteresis window before gating it off. It sits in the clock-gating fabric next to the gating cell, one instance per gated branch, and is clocked by the free-running (ungated) clock.

## Interface

Parameters:
- `WAKE_DLY`, default 2: cycles from `clken` assertion to `clkack` assertion; legal range is 1 to 15.
- `HYST_W`, default 4: width of the hysteresis count input.

Ports:
- `clk`, input, 1: free-running clock. One clock domain only.
- `rst_b`, input, 1: reset, asynchronous assert, active-low.
- `clkreq`, input, 1: clock request. It is synchronous to `clk`; any synchronizer is external.
- `force_on`, input, 1: debug/DFT override that keeps the clock running regardless of `clkreq`.
- `hyst_val`, input, `HYST_W`: number of idle cycles before gating off. It is sampled on entry to IDLE.
- `clken`, output, 1: enable to the gating cell; 1 means the clock runs. Registered.
- `clkack`, output, 1: handshake acknowledge. Registered.
- `gate_state`, output, 2: current FSM state, encoded OFF=0, WAKE=1, ON=2, IDLE=3.

## Operation

- `req_any = clkreq | force_on`.
- OFF (`clken`=0, `clkack`=0):
  - If `req_any`=1, go to WAKE and load the wake counter with `WAKE_DLY`.
- WAKE (`clken`=1, `clkack`=0):
  - The wake counter decrements each cycle.
  - When it reaches 0, go to ON.
  - The wake sequence is never aborted. If `req_any` drops during WAKE, the block still completes to ON and then follows the ON rules.
- ON (`clken`=1, `clkack`=1):
  - If `req_any`=0 and `hyst_val`=0, go to OFF.
  - If `req_any`=0 and `hyst_val`>0, go to IDLE and load the hysteresis counter with `hyst_val`.
- IDLE (`clken`=1, `clkack`=1):
  - If `req_any`=1, return to ON and clear the counter.
  - Otherwise the counter decrements. When it reaches 0, go to OFF.
  - IDLE therefore lasts exactly `hyst_val` cycles when uninterrupted.
- Handshake rules:
  - `clkack` rises only after `clken` has been high for `WAKE_DLY` cycles.
  - `clkack` falls in the same cycle `clken` falls.
  - Requesters must hold `clkreq` high until they see `clkack`=1.
  - Requesters must not reassert `clkreq` until they see `clkack`=0. A reassertion during IDLE is legal and cancels the gate-off.
- `clken` must never toggle other than at state transitions. `clken` and `clkack` come directly from flops with no combinational logic after them, so the gating cell sees a glitch-free enable.
- `force_on` held high keeps the block in ON indefinitely. When `force_on` is released, normal IDLE/OFF behaviour resumes.
- `hyst_val` changes take effect only at the next ON→IDLE entry.
- Counter widths:
  - The wake counter is `$clog2(WAKE_DLY+1)` bits.
  - The hysteresis counter is `HYST_W` bits.
  - Neither counter wraps; both saturate at 0.

## Timing

- Reset (`rst_b`=0, asynchronous):
  - State goes to OFF and both counters to 0.
  - `clken`=0, `clkack`=0, `gate_state`=0.
  - Reset mid-WAKE or mid-IDLE drops `clken` immediately. Release is synchronous; the first transition happens at the first `clk` edge after deassertion.
- Request latency, with `clkreq` sampled high at edge k while in OFF:
  - `clken`=1 and `gate_state`=1 after edge k.
  - `clkack`=1 after edge k+`WAKE_DLY`.
- Release latency, with `clkreq` sampled low at edge m while in ON:
  - With `hyst_val`=N>0, state is IDLE after m, and `clken`/`clkack` fall after edge m+N.
  - With N=0, they fall after edge m.
- Simultaneous events:
  - `req_any`=1 on the same edge the IDLE counter would reach 0: the request wins, and the state goes to ON.
  - `force_on` rising during WAKE: no effect on the WAKE duration.
- Minimum OFF dwell is 1 cycle. OFF→WAKE is allowed on the edge after entering OFF.

## Test plan

- **Reset:** assert `rst_b`=0 mid-WAKE with `WAKE_DLY`=2 → `clken`=0, `clkack`=0, `gate_state`=0 immediately. After release with `clkreq`=0, the block stays OFF.
- **Basic handshake:** `WAKE_DLY`=2, `clkreq` rises at edge 10 → `clken`=1 after edge 10, `clkack`=1 after edge 12. With `hyst_val`=3 and `clkreq` dropping at edge 20 → state IDLE for edges 20–22, then `clken`=`clkack`=0 after edge 23.
- **Zero hysteresis:** `hyst_val`=0, `clkreq` drops in ON at edge m → OFF and both outputs low after edge m. The IDLE state is never visited.
- **Re-request in IDLE:** `hyst_val`=5, `clkreq` drops, then reasserts 2 cycles into IDLE → returns to ON. `clken` and `clkack` never drop.
- **Collision:** with `hyst_val`=4, reassert `clkreq` on the edge where the IDLE counter reaches 0 → state goes to ON, not OFF.
- **Override:**
  - `force_on`=1 with `clkreq`=0 → full wake, then held in ON for more than 100 cycles.
  - Release `force_on` with `hyst_val`=2 → OFF after 2 IDLE cycles.
  - `clkreq` dropping during WAKE → the block still reaches ON, then IDLE.
